// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one width x height frame of source pixels into the
// edge pipeline, then drives zero pixels for FLUSH cycles to drain it.
module frame_sequencer #(
    parameter int FLUSH   = 403,
    parameter int MIN_DIM = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Abort,
    input  logic [7:0] CfgWidth,
    input  logic [7:0] CfgHeight,
    input  logic [7:0] SrcPixel,
    input  logic       SrcValid,
    output logic       SrcReady,
    output logic [7:0] PixelOut,
    output logic       FrameOut,
    output logic       LineOut,
    output logic       Busy,
    output logic       Done,
    output logic       CfgErr,
    output logic       Underflow
);

    localparam int              FW         = $clog2(FLUSH + 1);
    localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH - 1);
    localparam logic [7:0]      MIN_DIM8   = 8'(MIN_DIM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH
    } state_t;

    state_t        state;
    logic [7:0]    width_q;
    logic [7:0]    height_q;
    logic [7:0]    col;
    logic [7:0]    row;
    logic [FW-1:0] flush_cnt;

    logic cfg_ok;
    logic last_col;
    logic last_row;

    assign cfg_ok   = (CfgWidth >= MIN_DIM8) && (CfgHeight >= MIN_DIM8);
    assign last_col = (col == width_q - 8'd1);
    assign last_row = (row == height_q - 8'd1);

    // The source handshake is the only combinational output.
    assign SrcReady = (state == ST_ACTIVE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            width_q   <= 8'd0;
            height_q  <= 8'd0;
            col       <= 8'd0;
            row       <= 8'd0;
            flush_cnt <= '0;
            PixelOut  <= 8'd0;
            FrameOut  <= 1'b0;
            LineOut   <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            CfgErr    <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            // Pulses and pixel outputs fall back to zero unless a branch drives them.
            Done     <= 1'b0;
            CfgErr   <= 1'b0;
            PixelOut <= 8'd0;
            FrameOut <= 1'b0;
            LineOut  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (cfg_ok) begin
                            width_q   <= CfgWidth;
                            height_q  <= CfgHeight;
                            col       <= 8'd0;
                            row       <= 8'd0;
                            Underflow <= 1'b0;
                            state     <= ST_ACTIVE;
                            Busy      <= 1'b1;
                        end else begin
                            CfgErr <= 1'b1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (Abort) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        // The pipeline never stalls: a starved cycle emits a zero pixel.
                        PixelOut <= SrcValid ? SrcPixel : 8'd0;
                        if (!SrcValid) begin
                            Underflow <= 1'b1;
                        end
                        LineOut  <= (col == 8'd0);
                        FrameOut <= (col == 8'd0) && (row == 8'd0);
                        if (last_col) begin
                            col <= 8'd0;
                            if (last_row) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= '0;
                            end else begin
                                row <= row + 8'd1;
                            end
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (Abort) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: frame timing, config rejection, underflow,
// abort and reset behaviour, with hand-derived expected values.
module tb_frame_sequencer;

    localparam int FLUSH_CYC = 6;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Abort;
    logic [7:0] CfgWidth;
    logic [7:0] CfgHeight;
    logic [7:0] SrcPixel;
    logic       SrcValid;
    logic       SrcReady;
    logic [7:0] PixelOut;
    logic       FrameOut;
    logic       LineOut;
    logic       Busy;
    logic       Done;
    logic       CfgErr;
    logic       Underflow;

    int checkCount = 0;
    int errorCount = 0;

    frame_sequencer #(.FLUSH(FLUSH_CYC), .MIN_DIM(3)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Abort(Abort),
        .CfgWidth(CfgWidth),
        .CfgHeight(CfgHeight),
        .SrcPixel(SrcPixel),
        .SrcValid(SrcValid),
        .SrcReady(SrcReady),
        .PixelOut(PixelOut),
        .FrameOut(FrameOut),
        .LineOut(LineOut),
        .Busy(Busy),
        .Done(Done),
        .CfgErr(CfgErr),
        .Underflow(Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clock edge, then settle so registered outputs reflect that edge.
    task automatic applyStimulus();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pixel"}, 32'(PixelOut), 0);
        checkOutput({tag, ".frame"}, 32'(FrameOut), 0);
        checkOutput({tag, ".line"}, 32'(LineOut), 0);
        checkOutput({tag, ".busy"}, 32'(Busy), 0);
        checkOutput({tag, ".done"}, 32'(Done), 0);
        checkOutput({tag, ".cfgerr"}, 32'(CfgErr), 0);
        checkOutput({tag, ".underflow"}, 32'(Underflow), 0);
        checkOutput({tag, ".ready"}, 32'(SrcReady), 0);
    endtask

    // Issue an accepted Start; the following cycle is the first ACTIVE cycle.
    task automatic startFrame(input int w, input int h);
        CfgWidth  = 8'(w);
        CfgHeight = 8'(h);
        Start     = 1'b1;
        applyStimulus();
        Start = 1'b0;
        checkOutput("start.busy", 32'(Busy), 1);
        checkOutput("start.ready", 32'(SrcReady), 1);
        checkOutput("start.cfgerr", 32'(CfgErr), 0);
        checkOutput("start.underflow", 32'(Underflow), 0);
    endtask

    // Stream w*h pixels (base+i), optionally starving pixel dropAt, pulsing Start
    // at pixel startAt or on the last flush cycle, or aborting at flush cycle abortAt.
    task automatic runFrame(input int w, input int h, input int base, input int dropAt,
                            input int startAt, input bit startOnLast, input int abortAt);
        int doneSeen;
        for (int i = 1; i <= w * h; i++) begin
            SrcPixel = 8'(base + i);
            SrcValid = (i != dropAt);
            if (i == startAt) begin
                Start     = 1'b1;
                CfgWidth  = 8'd3;
                CfgHeight = 8'd3;
            end
            applyStimulus();
            Start = 1'b0;
            checkOutput($sformatf("px%0d.pixel", i), 32'(PixelOut), (i == dropAt) ? 0 : 32'((base + i) & 8'hFF));
            checkOutput($sformatf("px%0d.line", i), 32'(LineOut), 32'((i - 1) % w == 0));
            checkOutput($sformatf("px%0d.frame", i), 32'(FrameOut), 32'(i == 1));
            checkOutput($sformatf("px%0d.busy", i), 32'(Busy), 1);
            checkOutput($sformatf("px%0d.cfgerr", i), 32'(CfgErr), 0);
        end
        SrcValid = 1'b0;
        for (int k = 1; k <= FLUSH_CYC; k++) begin
            Abort = (k == abortAt);
            Start = startOnLast && (k == FLUSH_CYC);
            applyStimulus();
            Start = 1'b0;
            if (k == abortAt) begin
                Abort = 1'b0;
                checkOutput("abortflush.busy", 32'(Busy), 0);
                checkOutput("abortflush.done", 32'(Done), 0);
                checkOutput("abortflush.ready", 32'(SrcReady), 0);
                doneSeen = 0;
                for (int j = 0; j < FLUSH_CYC + 2; j++) begin
                    applyStimulus();
                    doneSeen += int'(Done);
                end
                checkOutput("abortflush.nodone", 32'(doneSeen), 0);
                return;
            end
            if (k < FLUSH_CYC) begin
                checkOutput($sformatf("fl%0d.done", k), 32'(Done), 0);
                checkOutput($sformatf("fl%0d.pixel", k), 32'(PixelOut), 0);
                checkOutput($sformatf("fl%0d.line", k), 32'(LineOut), 0);
                checkOutput($sformatf("fl%0d.busy", k), 32'(Busy), 1);
            end else begin
                checkOutput("flend.done", 32'(Done), 1);
                checkOutput("flend.busy", 32'(Busy), 0);
                checkOutput("flend.cfgerr", 32'(CfgErr), 0);
            end
        end
        applyStimulus();
        checkOutput("post.done", 32'(Done), 0);
        checkOutput("post.busy", 32'(Busy), 0);
        checkOutput("post.ready", 32'(SrcReady), 0);
        checkOutput("post.cfgerr", 32'(CfgErr), 0);
    endtask

    initial begin
        int lines;
        int frames;
        Reset     = 1'b1;
        Start     = 1'b0;
        Abort     = 1'b0;
        CfgWidth  = 8'd0;
        CfgHeight = 8'd0;
        SrcPixel  = 8'd0;
        SrcValid  = 1'b0;
        applyStimulus();
        checkAllZero("reset");
        applyStimulus();
        Reset = 1'b0;
        applyStimulus();
        checkAllZero("idle");

        $display("[TB] basic 4x3 frame");
        startFrame(4, 3);
        runFrame(4, 3, 0, 0, 0, 1'b0, 0);

        $display("[TB] rejected configurations");
        CfgWidth  = 8'd2;
        CfgHeight = 8'd5;
        Start     = 1'b1;
        applyStimulus();
        Start = 1'b0;
        checkOutput("cfg25.cfgerr", 32'(CfgErr), 1);
        checkOutput("cfg25.busy", 32'(Busy), 0);
        checkOutput("cfg25.ready", 32'(SrcReady), 0);
        applyStimulus();
        checkOutput("cfg25.pulse", 32'(CfgErr), 0);
        checkOutput("cfg25.ready2", 32'(SrcReady), 0);
        CfgWidth  = 8'd5;
        CfgHeight = 8'd2;
        Start     = 1'b1;
        applyStimulus();
        Start = 1'b0;
        checkOutput("cfg52.cfgerr", 32'(CfgErr), 1);
        checkOutput("cfg52.busy", 32'(Busy), 0);

        $display("[TB] underflow on pixel 5 of 3x3");
        startFrame(3, 3);
        runFrame(3, 3, 16, 5, 0, 1'b0, 0);
        checkOutput("uf.sticky", 32'(Underflow), 1);
        CfgWidth  = 8'd2;
        CfgHeight = 8'd2;
        Start     = 1'b1;
        applyStimulus();
        Start = 1'b0;
        checkOutput("uf.rejectkeeps", 32'(Underflow), 1);
        checkOutput("uf.rejecterr", 32'(CfgErr), 1);

        $display("[TB] abort two cycles into flush");
        startFrame(3, 3);
        runFrame(3, 3, 32, 0, 0, 1'b0, 2);
        startFrame(4, 3);
        runFrame(4, 3, 40, 0, 0, 1'b0, 0);

        $display("[TB] abort on last flush cycle");
        startFrame(3, 3);
        runFrame(3, 3, 48, 0, 0, 1'b0, FLUSH_CYC);

        $display("[TB] abort mid-frame on a line start");
        startFrame(4, 3);
        SrcValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            SrcPixel = 8'(i + 100);
            applyStimulus();
        end
        SrcPixel = 8'd105;
        Abort    = 1'b1;
        applyStimulus();
        Abort = 1'b0;
        checkOutput("abortact.pixel", 32'(PixelOut), 0);
        checkOutput("abortact.line", 32'(LineOut), 0);
        checkOutput("abortact.busy", 32'(Busy), 0);
        checkOutput("abortact.ready", 32'(SrcReady), 0);
        applyStimulus();
        checkOutput("abortact.idle", 32'(Busy), 0);

        $display("[TB] abort in idle, abort with start");
        Abort = 1'b1;
        applyStimulus();
        checkOutput("abortidle.busy", 32'(Busy), 0);
        checkOutput("abortidle.cfgerr", 32'(CfgErr), 0);
        startFrame(3, 3);
        Abort = 1'b0;
        runFrame(3, 3, 56, 0, 0, 1'b0, 0);

        $display("[TB] start ignored while active and on done cycle");
        startFrame(4, 3);
        runFrame(4, 3, 64, 0, 5, 1'b1, 0);

        $display("[TB] full 255x255 frame");
        startFrame(255, 255);
        lines    = 0;
        frames   = 0;
        SrcValid = 1'b1;
        SrcPixel = 8'h5A;
        for (int i = 1; i <= 255 * 255; i++) begin
            applyStimulus();
            lines  += int'(LineOut);
            frames += int'(FrameOut);
        end
        checkOutput("big.lastpixel", 32'(PixelOut), 32'h5A);
        checkOutput("big.busy", 32'(Busy), 1);
        checkOutput("big.lines", 32'(lines), 255);
        checkOutput("big.frames", 32'(frames), 1);
        SrcValid = 1'b0;
        for (int k = 1; k < FLUSH_CYC; k++) begin
            applyStimulus();
        end
        checkOutput("big.predone", 32'(Done), 0);
        applyStimulus();
        checkOutput("big.done", 32'(Done), 1);
        checkOutput("big.idle", 32'(Busy), 0);

        $display("[TB] reset mid-row of 255x255 frame");
        startFrame(255, 255);
        SrcPixel = 8'hA5;
        for (int i = 1; i <= 300; i++) begin
            SrcValid = (i != 100);
            applyStimulus();
        end
        checkOutput("rst.preunderflow", 32'(Underflow), 1);
        checkOutput("rst.prepixel", 32'(PixelOut), 32'hA5);
        Reset = 1'b1;
        applyStimulus();
        checkAllZero("rstmid");
        Start     = 1'b1;
        Abort     = 1'b1;
        CfgWidth  = 8'd4;
        CfgHeight = 8'd3;
        applyStimulus();
        checkOutput("rst.dominates", 32'(Busy), 0);
        Reset = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        applyStimulus();
        startFrame(4, 3);
        runFrame(4, 3, 80, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
